// File: rtl/fifo_stream_out_if.sv
// Bundle between fifo_stream_out, the dual-clock FIFO read port and the stream sink.
// out_cnt exists only when FIFO_STREAM_OUT_CNT_EN is defined.
interface fifo_stream_out_if #(
    parameter int D_WIDTH = 32
);
    logic               fifo_rd_en;
    logic [D_WIDTH-1:0] fifo_rd_data;
    logic               fifo_rd_empty;
    logic [D_WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
`ifdef FIFO_STREAM_OUT_CNT_EN
    logic [31:0]        out_cnt;
`endif

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_rd_empty,
        output out_data,
        output out_valid,
        input  out_ready
`ifdef FIFO_STREAM_OUT_CNT_EN
        , output out_cnt
`endif
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_rd_empty,
        input  out_data,
        input  out_valid,
        output out_ready
`ifdef FIFO_STREAM_OUT_CNT_EN
        , input out_cnt
`endif
    );
endinterface

// File: rtl/fifo_stream_out.sv
// FIFO pull-port to valid/ready stream adapter with a 2-entry holding buffer.
// Optional accepted-beat counter on out_cnt when FIFO_STREAM_OUT_CNT_EN is defined.
module fifo_stream_out #(
    parameter int D_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    fifo_stream_out_if.master   bus
);
    logic [D_WIDTH-1:0] slot_p1 [2];
    logic               head_p1;
    logic [1:0]         cnt_p1;
    logic               inflight_p0;

    logic               pop;
    logic [2:0]         occ_next;
    logic               rd_en;
    logic               wr_idx;

    assign pop      = bus.out_valid & bus.out_ready;
    assign occ_next = {1'b0, cnt_p1} + {2'b00, inflight_p0} - {2'b00, pop};
    assign rd_en    = rst_n_i & ~bus.fifo_rd_empty & (occ_next < 3'd2);
    // The free slot behind the queued words is head+cnt whether or not the head word leaves now.
    assign wr_idx   = head_p1 ^ cnt_p1[0];

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = (cnt_p1 != 2'd0);
    assign bus.out_data   = slot_p1[head_p1];

    // Stage 0 -> 1: strobe issued last cycle, FIFO word captured into the buffer now
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_p1[0]  <= '0;
            slot_p1[1]  <= '0;
            head_p1     <= 1'b0;
            cnt_p1      <= 2'd0;
            inflight_p0 <= 1'b0;
        end else begin
            if (inflight_p0) begin
                slot_p1[wr_idx] <= bus.fifo_rd_data;
            end
            if (pop) begin
                head_p1 <= ~head_p1;
            end
            cnt_p1      <= occ_next[1:0];
            inflight_p0 <= rd_en;
        end
    end

`ifdef FIFO_STREAM_OUT_CNT_EN
    logic [31:0] beat_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_cnt <= 32'd0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end

    assign bus.out_cnt = beat_cnt;
`endif
endmodule
